// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder scheduler.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sched_fa_bit.sv
// Single 1-bit full-adder cell shared by both requesters.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester scheduler around one bit-serial full adder: grant, shift LSB-first, hold result.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic             last_served;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             id_q;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    // Round-robin on a tie: favour whoever was not served last.
    always_comb begin
        grant_id = 1'b0;
        if (in0_valid && in1_valid) begin
            grant_id = ~last_served;
        end else if (in1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Readies are masked by rst so they read 0 even before the first reset edge.
    assign in0_ready = (state == IDLE) && !rst && in0_valid && !grant_id;
    assign in1_ready = (state == IDLE) && !rst && in1_valid &&  grant_id;
    assign accept    = in0_ready | in1_ready;

    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (s_bit),
        .cout (c_bit)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            c_q         <= 1'b0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            id_q        <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q         <= grant_id ? in1_a : in0_a;
                        b_q         <= grant_id ? in1_b : in0_b;
                        id_q        <= grant_id;
                        last_served <= grant_id;
                        c_q         <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    // Shift form stays legal when WIDTH is 1.
                    sum_q <= (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                    c_q   <= c_bit;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = c_q;
    assign out_id   = id_q;

endmodule

// File: doc/serial_add_sched.md
SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be >= 1.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in0_valid  in  1  requester 0 has an operand pair.
REQ-005 in0_ready  out  1  requester 0 pair accepted this cycle.
REQ-006 in0_a, in0_b  in  WIDTH  requester 0 operands.
REQ-007 in1_valid, in1_ready, in1_a, in1_b  as REQ-004..006, for requester 1.
REQ-008 out_valid  out  1  result available.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 out_sum  out  WIDTH  a+b modulo 2^WIDTH.
REQ-011 out_cout  out  1  carry out of the MSB.
REQ-012 out_id  out  1  requester that owns the result.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 Block SHALL share one 1-bit full-adder cell between two requesters, adding operands bit-serially LSB first.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 IDLE: grant to the only valid requester; if both valid, grant the one not served last; last-served SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 inN_ready SHALL be high only in IDLE and only for the granted requester; it is combinational on inN_valid and the grant.
REQ-018 On an accept (valid & ready): capture a, b, id; clear carry and bit counter; update last-served; go to SHIFT.
REQ-019 SHIFT, each cycle: sum bit = a[0]^b[0]^c; c = maj(a[0],b[0],c); shift a, b right; shift sum bit into the result MSB; increment counter.
REQ-020 After exactly WIDTH SHIFT cycles, go to DONE; the counter is clog2(WIDTH+1) bits wide.
REQ-021 DONE: out_valid=1; out_sum, out_cout and out_id SHALL hold stable until out_valid & out_ready.
REQ-022 On the output handshake, return to IDLE; a new grant SHALL NOT occur in that same cycle.
REQ-023 Latency: accept at cycle T gives out_valid at cycle T+WIDTH+1; throughput is one operation per WIDTH+2 cycles minimum.
REQ-024 In SHIFT and DONE, both readies SHALL be 0; requester valids and operands are ignored.
REQ-025 A requester dropping valid before grant SHALL lose nothing; no request SHALL be queued internally.
REQ-026 With WIDTH=1, SHIFT SHALL last exactly one cycle.

Reset
REQ-027 rst SHALL force IDLE, last-served=1, carry=0 and counter=0.
REQ-028 During and after rst, all outputs SHALL be 0: readies, out_valid, out_sum, out_cout, out_id and busy.
REQ-029 rst asserted in SHIFT or DONE SHALL abort the operation; no result SHALL be produced for it.

Structure
REQ-030 Shared package serial_add_pkg SHALL hold the FSM state type and the default WIDTH constant.
REQ-031 The full-adder cell SHALL be a sub-module fa_bit, with inputs a, b, cin and outputs s, cout, instantiated once.

Verification
REQ-032 WIDTH=8: req0 a=3, b=5 -> out_sum=8, out_cout=0, out_id=0, out_valid exactly 9 cycles after the accept.
REQ-033 req1 a=0xFF, b=0x01 -> out_sum=0x00, out_cout=1, out_id=1.
REQ-034 Both valid continuously after reset with out_ready=1 -> service order by out_id SHALL be 0,1,0,1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_sum, out_cout and out_id unchanged, both readies 0, then one handshake.
REQ-036 Pulse rst in the 4th SHIFT cycle -> busy=0 and out_valid=0 the next cycle; a subsequent 7+9 SHALL return 16.
REQ-037 Random a/b, 1000 operations -> every {out_cout, out_sum} SHALL equal a+b, checked against a model.
